leaf_out_arbiter: RTL and testbench
===================================

// Module: leaf_out_arbiter
// PURPOSE
//  Round-robin, burst-limited arbiter that shares one leaf's BFT output packet slot among NUM_REQ
//  packet sources (stream flow control, config echo, debug). Sits between the sources and the
//  leaf's dout-to-BFT path. Honours the switch's resend back-pressure by holding the emitted packet.
// PARAMETERS
//  PACKET_BITS  49  width of a BFT packet; bit PACKET_BITS-1 is the packet-valid flag
//  NUM_REQ      4   number of requesters, 2..8
//  BURST_LEN    4   max consecutive packets granted to one requester before rotation, 1..15
//  CNT_BITS     16  width of the statistics counters
// PORTS
//  clk          in   1                       clock
//  reset        in   1                       synchronous, active-high
//  req_vld      in   NUM_REQ                 requester i has a packet on req_din[i]
//  req_din      in   (PACKET_BITS-1)*NUM_REQ packet body of requester i, without the valid flag
//  req_ack      out  NUM_REQ                 one-hot, combinational: packet of requester i taken this cycle
//  dout         out  PACKET_BITS             registered packet to BFT; all zeros = idle slot
//  resend       in   1                       switch did not accept dout; present it again
//  grant_owner  out  3                       index of the current burst owner (registered)
//  busy         out  1                       1 while in state BURST
//  pkt_cnt      out  CNT_BITS                packets emitted; saturates at all-ones
//  resend_cnt   out  CNT_BITS                cycles with resend=1 and dout valid; saturates
// BEHAVIOUR
//  Reset: dout=0, state=IDLE, owner=NUM_REQ-1 (first search starts at 0), burst_cnt=0, busy=0,
//    pkt_cnt=0, resend_cnt=0. req_ack is 0 during reset.
//  States:
//    IDLE   no owner
//    BURST  owner holds the grant; burst_cnt = packets sent in the current burst (1..BURST_LEN)
//  Resend (highest priority): resend=1 in cycle t ->
//    - req_ack=0
//    - dout, state, owner and burst_cnt are held at t+1
//    - resend_cnt++ if dout[PACKET_BITS-1]=1
//  Selection, resend=0 (combinational in cycle t, registered at t+1):
//    - If BURST, req_vld[owner]=1 and burst_cnt<BURST_LEN: sel=owner; burst_cnt++.
//    - Otherwise search req_vld circularly from owner+1 (mod NUM_REQ) and take the first set bit:
//      sel=that index, owner<=sel, burst_cnt<=1, state<=BURST.
//    - Search wraps to owner itself last, so a lone requester whose burst ended is re-granted at once.
//    - No req_vld set: state<=IDLE, dout<=0, owner is kept for the next rotation.
//  Emit: when sel is found,
//    - req_ack[sel]=1 in cycle t
//    - dout<={1'b1, req_din[sel]} at t+1
//    - pkt_cnt++
//    Latency from ack to dout is 1 cycle.
//  Handshake: a requester holds req_din stable while req_vld=1 and req_ack=0. It may drop req_vld
//    at any time; a drop ends its burst. req_ack is never asserted to a requester with req_vld=0.
//  Width rules:
//    - burst_cnt is 4 bits and never exceeds BURST_LEN.
//    - Counters saturate at 2^CNT_BITS-1 and never wrap.
//    - owner index is zero-extended onto grant_owner.
//  Boundary cases:
//    - resend with dout idle: hold zeros, no ack.
//    - resend on consecutive cycles: hold for every cycle.
//    - reset mid-burst: all state returns to reset values next cycle, with no ack in the reset cycle.
// TESTING
//  1. req_vld=4'b0001 continuous, BURST_LEN=4 -> ack0 every cycle, pkt_cnt=8 after 8 cycles,
//     dout valid-bit=1 from cycle 2.
//  2. req_vld=4'b1111 continuous -> ack pattern 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; grant_owner tracks it.
//  3. req_vld=4'b0101, req0 drops after 2 packets -> req2 granted the next cycle with burst_cnt=1.
//  4. resend=1 for 3 cycles while dout=packet P -> dout=P for those cycles plus 1, no ack,
//     resend_cnt=3, then the sequence resumes.
//  5. reset asserted mid-burst (owner=2, burst_cnt=3) -> next cycle dout=0, busy=0, counters 0;
//     after release req_vld=4'b0100 -> req2 wins, search starting at 0.
//  6. pkt_cnt preloaded near 16'hFFFE, 4 packets sent -> pkt_cnt sticks at 16'hFFFF.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin, burst-limited sharing of one leaf's BFT
// output packet slot among NUM_REQ packet sources, with resend hold.
//
//   state | meaning
//   IDLE  | no owner; dout carries an idle (all-zero) slot
//   BURST | owner holds the grant; burst_cnt = packets sent in this burst
module leaf_out_arbiter #(
  parameter int PACKET_BITS = 49,
  parameter int NUM_REQ     = 4,
  parameter int BURST_LEN   = 4,
  parameter int CNT_BITS    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_vld,
  input  logic [(PACKET_BITS-1)*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]               req_ack,
  output logic [PACKET_BITS-1:0]           dout,
  input  logic                             resend,
  output logic [2:0]                       grant_owner,
  output logic                             busy,
  output logic [CNT_BITS-1:0]              pkt_cnt,
  output logic [CNT_BITS-1:0]              resend_cnt
);

  localparam int BW = PACKET_BITS - 1;
  localparam int OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d, sel;
  logic [3:0]             burst_q, burst_d;
  logic [PACKET_BITS-1:0] dout_d;
  logic                   emit, found;
  int                     idx;

  // Next-state, selection and ack; resend freezes everything and acks nothing.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    dout_d  = dout;
    req_ack = '0;
    emit    = 1'b0;
    found   = 1'b0;
    sel     = owner_q;
    idx     = 0;
    if (!reset && !resend) begin
      if (state_q == BURST && req_vld[owner_q] && burst_q < 4'(BURST_LEN)) begin
        found   = 1'b1;
        sel     = owner_q;
        burst_d = burst_q + 4'd1;
      end else begin
        // Circular search from owner+1; the owner itself is tried last so a
        // lone requester whose burst just ended is re-granted immediately.
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (int'(owner_q) + k) % NUM_REQ;
          if (!found && req_vld[idx]) begin
            found = 1'b1;
            sel   = OW'(idx);
          end
        end
        if (found) begin
          owner_d = sel;
          burst_d = 4'd1;
          state_d = BURST;
        end else begin
          state_d = IDLE;
          burst_d = 4'd0;
        end
      end
      if (found) begin
        emit         = 1'b1;
        req_ack[sel] = 1'b1;
        dout_d       = {1'b1, req_din[int'(sel)*BW +: BW]};
      end else begin
        dout_d = '0;
      end
    end
  end

  // State, owner, burst count and output packet registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OW'(NUM_REQ - 1);
      burst_q <= 4'd0;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      dout    <= dout_d;
    end
  end

  // Saturating statistics: emitted packets and resend cycles on a valid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt    <= '0;
      resend_cnt <= '0;
    end else begin
      if (emit && pkt_cnt != '1)
        pkt_cnt <= pkt_cnt + CNT_BITS'(1);
      if (resend && dout[PACKET_BITS-1] && resend_cnt != '1)
        resend_cnt <= resend_cnt + CNT_BITS'(1);
    end
  end

  assign busy        = (state_q == BURST);
  assign grant_owner = 3'(owner_q);

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter; a second instance with 3-bit counters
// shares the stimulus so counter saturation is reached quickly.
module tb_leaf_out_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_vld;
  logic [191:0] req_din;
  logic [3:0]  req_ack, sat_ack;
  logic [48:0] dout, sat_dout;
  logic        resend;
  logic [2:0]  grant_owner, sat_owner;
  logic        busy, sat_busy;
  logic [15:0] pkt_cnt, resend_cnt;
  logic [2:0]  sat_pkt, sat_rs;

  logic [47:0] din [4];
  logic [48:0] exp_dout;
  int          exp_pkt, exp_rs;
  int          checks = 0, passes = 0, fails = 0;

  assign req_din = {din[3], din[2], din[1], din[0]};

  always #5 clk = ~clk;

  leaf_out_arbiter u_dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_din(req_din),
    .req_ack(req_ack), .dout(dout), .resend(resend), .grant_owner(grant_owner),
    .busy(busy), .pkt_cnt(pkt_cnt), .resend_cnt(resend_cnt)
  );

  leaf_out_arbiter #(.CNT_BITS(3)) u_sat (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_din(req_din),
    .req_ack(sat_ack), .dout(sat_dout), .resend(resend), .grant_owner(sat_owner),
    .busy(sat_busy), .pkt_cnt(sat_pkt), .resend_cnt(sat_rs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational ack, clock, check registered outputs.
  task automatic step(input logic [3:0] vld, input logic rs, input logic [3:0] ea);
    int idx = -1;
    req_vld = vld;
    resend  = rs;
    #1;
    chk("req_ack", req_ack, ea);
    chk("sat_ack", sat_ack, ea);
    for (int i = 0; i < 4; i++) if (ea[i]) idx = i;
    if (rs) begin
      if (exp_dout[48]) exp_rs++;
    end else if (idx >= 0) begin
      exp_dout = {1'b1, din[idx]};
      exp_pkt++;
    end else begin
      exp_dout = '0;
    end
    @(posedge clk); #1;
    chk("dout", dout, exp_dout);
    chk("pkt_cnt", pkt_cnt, exp_pkt);
    chk("resend_cnt", resend_cnt, exp_rs);
    if (idx >= 0 && !rs) din[idx] = din[idx] + 48'h0000_0001_0001;
  endtask

  task automatic do_reset(input logic [3:0] vld);
    reset   = 1'b1;
    req_vld = vld;
    resend  = 1'b0;
    #1;
    chk("ack_in_reset", req_ack, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_dout", dout, 49'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", grant_owner, 3'd3);
    chk("rst_pkt", pkt_cnt, 16'd0);
    chk("rst_rs", resend_cnt, 16'd0);
    chk("rst_sat_pkt", sat_pkt, 3'd0);
    reset    = 1'b0;
    exp_dout = '0;
    exp_pkt  = 0;
    exp_rs   = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = {8'(8'hA0 + i), 40'h0};
    reset = 1'b1; req_vld = '0; resend = 1'b0;
    exp_dout = '0; exp_pkt = 0; exp_rs = 0;
    @(posedge clk); #1;

    // Reset state, with every requester asking during reset.
    do_reset(4'b1111);

    // Lone requester: acked every cycle including across burst boundaries.
    for (int k = 0; k < 8; k++) step(4'b0001, 1'b0, 4'b0001);
    chk("t1_pkt8", pkt_cnt, 16'd8);
    chk("t1_busy", busy, 1'b1);
    chk("t1_owner", grant_owner, 3'd0);
    chk("t1_sat_pkt", sat_pkt, 3'd7);

    // All requesting: bursts of four, rotating 0,1,2,3,0.
    do_reset(4'b0000);
    for (int k = 0; k < 17; k++) begin
      step(4'b1111, 1'b0, 4'(1 << ((k / 4) % 4)));
      chk("t2_owner", grant_owner, 3'((k / 4) % 4));
    end
    chk("t2_sat_pkt", sat_pkt, 3'd7);

    // req0 drops after two packets; req2 gets a fresh burst of four.
    do_reset(4'b0000);
    step(4'b0101, 1'b0, 4'b0001);
    step(4'b0101, 1'b0, 4'b0001);
    step(4'b0100, 1'b0, 4'b0100);
    chk("t3_owner2", grant_owner, 3'd2);
    step(4'b0101, 1'b0, 4'b0100);
    step(4'b0101, 1'b0, 4'b0100);
    step(4'b0101, 1'b0, 4'b0100);
    step(4'b0101, 1'b0, 4'b0001);
    chk("t3_owner0", grant_owner, 3'd0);

    // Resend for three cycles holds dout, then the burst resumes.
    step(4'b0101, 1'b1, 4'b0000);
    step(4'b0101, 1'b1, 4'b0000);
    step(4'b0101, 1'b1, 4'b0000);
    chk("t4_rs3", resend_cnt, 16'd3);
    chk("t4_sat_rs3", sat_rs, 3'd3);
    step(4'b0101, 1'b0, 4'b0001);
    chk("t4_owner", grant_owner, 3'd0);

    // Idle slot, resend on idle slot, then a new search from owner+1.
    step(4'b0000, 1'b0, 4'b0000);
    chk("idle_busy", busy, 1'b0);
    chk("idle_owner_kept", grant_owner, 3'd0);
    step(4'b0000, 1'b1, 4'b0000);
    chk("idle_rs_nocount", resend_cnt, 16'd3);
    step(4'b0011, 1'b0, 4'b0010);
    chk("idle_owner1", grant_owner, 3'd1);

    // Reset mid-burst with owner 2 after three packets.
    do_reset(4'b0000);
    step(4'b0100, 1'b0, 4'b0100);
    step(4'b0100, 1'b0, 4'b0100);
    step(4'b0100, 1'b0, 4'b0100);
    chk("t5_owner2", grant_owner, 3'd2);
    do_reset(4'b0100);
    step(4'b0100, 1'b0, 4'b0100);
    chk("t5_owner_after", grant_owner, 3'd2);
    chk("t5_busy", busy, 1'b1);
    do_reset(4'b0000);
    step(4'b0101, 1'b0, 4'b0001);
    chk("t5_search_from0", grant_owner, 3'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
